kernel_window_loader: RTL and testbench
=======================================

Name: kernel_window_loader

Overview:
Feeder on the write side of the per-neighbourhood kernel RAMs.
- Walks every interior pixel of a padded N x N frame.
- For each interior pixel, reads its 3x3 neighbourhood from the synchronous frame RAM.
- Writes the nine taps into the kernel RAM selected by an identifier.
- Sits between the frame RAM and the centerMask kernel array; started once per skeletonization pass.

Parameters:
N, 8, padded frame width and height in pixels; interior centres are rows/cols 1..N-2.
bitSize, 6, address MSB index; addresses are bitSize+1 bits wide and must cover N*N-1.

Ports:
clk  in  1  system clock, all logic on rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  pass request; sampled only in IDLE.
busy  out  1  high from first FETCH through DONE inclusive.
done  out  1  one-cycle pulse in DONE state.
img_addr  out  bitSize+1  frame RAM read address, row*N+col.
img_data  in  8  frame RAM read data; valid the cycle after img_addr is presented.
kr_we  out  1  kernel RAM write enable.
kr_addr  out  bitSize+1  tap index 0..8, row-major; 4 = centre.
kr_data  out  8  tap pixel value.
kr_identifier  out  8  target kernel index, (r-1)*(N-2)+(c-1).

Behaviour:
- Reset (synchronous, highest priority): state=IDLE, all outputs 0, row/col/tap counters cleared.
  - Reset mid-pass aborts with no done pulse.
- States: IDLE, FETCH, WAIT, WRITE_A, WRITE_B, NEXT, DONE.
- IDLE: start=1 -> FETCH with r=1, c=1, tap=0.
  - start is ignored in every other state.
- FETCH: img_addr=(r-1+tap/3)*N+(c-1+tap%3) -> WAIT.
- WAIT: img_data registered at the end of the cycle -> WRITE_A.
- WRITE_A, WRITE_B: kr_we=1, with kr_addr=tap, kr_data=captured pixel, kr_identifier=current kernel index.
  - Write is held two cycles because the kernel RAM samples on alternate edges.
  - kr_addr/kr_data/kr_identifier change only on entry to WRITE_A and hold their values afterwards.
  - After WRITE_B: tap<8 -> tap+1, FETCH; tap==8 -> NEXT.
- NEXT: kr_we=0; tap=0; advance c.
  - c wraps from N-2 to 1 with r+1.
  - If r==N-2 and c==N-2 -> DONE, else FETCH.
- DONE: done=1, busy=1 for one cycle -> IDLE. A start sampled during DONE is ignored.
- Timing:
  - Per kernel: 9 taps x 4 cycles + 1 NEXT = 37 cycles.
  - N=8 gives 36 kernels; with start in cycle 0, the first FETCH is cycle 1, the last NEXT is cycle 1332, and DONE is cycle 1333.
- Width rules:
  - Address arithmetic is done in bitSize+1 bits; it cannot overflow for legal N.
  - kr_identifier is zero-extended to 8 bits; (N-2)^2 must be <= 256.
- img_addr holds its last value outside FETCH.

Optional Feature:
Macro BG_SKIP_EN.
- Defined:
  - Each kernel begins with a probe: FETCH then WAIT of tap 4 (centre).
  - If the captured value is 0 (background): no writes; go to NEXT; the identifier still advances. Such a kernel costs 3 cycles.
  - If nonzero: normal 9-tap sequence starting at tap 0. The probe adds 2 cycles, so the kernel costs 39 cycles.
- Undefined: no probe; every kernel is written, 37 cycles each.

Test Plan:
- Reset then pulse start; frame RAM holds pixel=address -> kernel 0 receives taps {0,1,2,8,9,10,16,17,18} at kr_addr 0..8 with kr_identifier=0, and each write has kr_we high for exactly 2 cycles.
- Full pass N=8 -> 36 distinct identifiers 0..35, 324 write pairs; done pulses exactly once at cycle 1333; busy low afterwards.
- Last kernel (r=6, c=6) -> identifier 35, taps {45,46,47,53,54,55,61,62,63}.
- start held high throughout the pass -> no restart until IDLE; a second pass begins the cycle after DONE+1.
- reset asserted at cycle 500 -> next cycle all outputs 0 and state IDLE, no done; a fresh start then completes a full 1333-cycle pass.
- BG_SKIP_EN with all-zero frame except pixel 9=1 -> only identifier 0 is written (9 writes); the other 35 kernels take 3 cycles each and perform no writes.

Source files
------------

// File: rtl/kernel_window_loader.sv
// Streams the 3x3 neighbourhood of every interior pixel of an N x N frame into kernel RAMs.
// Optional macro BG_SKIP_EN: probe the centre pixel first and skip kernels whose centre is 0.
module kernel_window_loader #(
    parameter int unsigned N       = 8,
    parameter int unsigned bitSize = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [bitSize:0] img_addr,
    input  logic [7:0]       img_data,
    output logic             kr_we,
    output logic [bitSize:0] kr_addr,
    output logic [7:0]       kr_data,
    output logic [7:0]       kr_identifier
);

    localparam int unsigned AW = bitSize + 1;
    localparam logic [AW-1:0] One  = AW'(1);
    localparam logic [AW-1:0] Last = AW'(N - 2);
    localparam logic [AW-1:0] NW   = AW'(N);

    typedef enum logic [2:0] {
        StIdle, StFetch, StWait, StWriteA, StWriteB, StNext, StDone
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] r_q, r_d, c_q, c_d;
    logic [3:0]    tap_q, tap_d;
    logic [7:0]    kid_q, kid_d;
    logic          busy_q, busy_d, done_q, done_d, kr_we_q, kr_we_d;
    logic [AW-1:0] img_addr_q, img_addr_d, kr_addr_q, kr_addr_d;
    logic [7:0]    kr_data_q, kr_data_d, kr_identifier_q, kr_identifier_d;
`ifdef BG_SKIP_EN
    logic          probe_q, probe_d;
`endif

    function automatic logic [AW-1:0] tap_row(input logic [3:0] t);
        if (t < 4'd3)      return AW'(0);
        else if (t < 4'd6) return AW'(1);
        else               return AW'(2);
    endfunction

    function automatic logic [AW-1:0] tap_col(input logic [3:0] t);
        case (t)
            4'd0, 4'd3, 4'd6: return AW'(0);
            4'd1, 4'd4, 4'd7: return AW'(1);
            default:          return AW'(2);
        endcase
    endfunction

    always_comb begin
        state_d         = state_q;
        r_d             = r_q;
        c_d             = c_q;
        tap_d           = tap_q;
        kid_d           = kid_q;
        img_addr_d      = img_addr_q;
        kr_addr_d       = kr_addr_q;
        kr_data_d       = kr_data_q;
        kr_identifier_d = kr_identifier_q;
`ifdef BG_SKIP_EN
        probe_d         = probe_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                    r_d     = One;
                    c_d     = One;
                    kid_d   = 8'd0;
`ifdef BG_SKIP_EN
                    tap_d   = 4'd4;
                    probe_d = 1'b1;
`else
                    tap_d   = 4'd0;
`endif
                end
            end
            StFetch: state_d = StWait;
            StWait: begin
`ifdef BG_SKIP_EN
                if (probe_q) begin
                    probe_d = 1'b0;
                    if (img_data == 8'd0) begin
                        state_d = StNext;
                    end else begin
                        state_d = StFetch;
                        tap_d   = 4'd0;
                    end
                end else
`endif
                begin
                    state_d         = StWriteA;
                    kr_addr_d       = AW'(tap_q);
                    kr_data_d       = img_data;
                    kr_identifier_d = kid_q;
                end
            end
            StWriteA: state_d = StWriteB;
            StWriteB: begin
                if (tap_q == 4'd8) begin
                    state_d = StNext;
                end else begin
                    state_d = StFetch;
                    tap_d   = tap_q + 4'd1;
                end
            end
            StNext: begin
                kid_d = kid_q + 8'd1;
                tap_d = 4'd0;
                if (r_q == Last && c_q == Last) begin
                    state_d = StDone;
                end else begin
                    state_d = StFetch;
`ifdef BG_SKIP_EN
                    tap_d   = 4'd4;
                    probe_d = 1'b1;
`endif
                    if (c_q == Last) begin
                        c_d = One;
                        r_d = r_q + One;
                    end else begin
                        c_d = c_q + One;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Outputs are registered, so decode them from the state being entered.
        if (state_d == StFetch) begin
            img_addr_d = (r_d - One + tap_row(tap_d)) * NW + (c_d - One + tap_col(tap_d));
        end
        busy_d  = (state_d != StIdle);
        done_d  = (state_d == StDone);
        kr_we_d = (state_d == StWriteA) || (state_d == StWriteB);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            r_q             <= '0;
            c_q             <= '0;
            tap_q           <= '0;
            kid_q           <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            kr_we_q         <= 1'b0;
            img_addr_q      <= '0;
            kr_addr_q       <= '0;
            kr_data_q       <= '0;
            kr_identifier_q <= '0;
`ifdef BG_SKIP_EN
            probe_q         <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            r_q             <= r_d;
            c_q             <= c_d;
            tap_q           <= tap_d;
            kid_q           <= kid_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            kr_we_q         <= kr_we_d;
            img_addr_q      <= img_addr_d;
            kr_addr_q       <= kr_addr_d;
            kr_data_q       <= kr_data_d;
            kr_identifier_q <= kr_identifier_d;
`ifdef BG_SKIP_EN
            probe_q         <= probe_d;
`endif
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign kr_we         = kr_we_q;
    assign img_addr      = img_addr_q;
    assign kr_addr       = kr_addr_q;
    assign kr_data       = kr_data_q;
    assign kr_identifier = kr_identifier_q;

endmodule

// File: tb/tb_kernel_window_loader.sv
// Randomised self-checking bench for kernel_window_loader against a frame-level write model.
module tb_kernel_window_loader;
    localparam int N  = 8;
    localparam int BS = 6;

    typedef struct {
        int id;
        int tap;
        int val;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, kr_we;
    logic [BS:0]   img_addr, kr_addr;
    logic [7:0]    img_data = 8'd0;
    logic [7:0]    kr_data, kr_identifier;
    logic [7:0]    mem [N*N];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int pc = 0;
    int t_exp = 0;
    int run = 0;
    bit chk_en = 1'b0;
    bit pass_fin = 1'b0;
    bit hold_mode = 1'b0;
    wr_t exp_q[$];
    wr_t log_q[$];

    kernel_window_loader #(.N(N), .bitSize(BS)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .img_addr(img_addr), .img_data(img_data), .kr_we(kr_we), .kr_addr(kr_addr),
        .kr_data(kr_data), .kr_identifier(kr_identifier)
    );

    always #5 clk = ~clk;

    always @(posedge clk) img_data <= mem[int'(img_addr)];

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (pass cycle %0d)", name, act, expv, pc);
        end
    endtask

    // Expected write stream and DONE cycle from the frame contents alone.
    task automatic build_model();
        int cost_sum;
        exp_q.delete();
        cost_sum = 0;
        for (int r = 1; r <= N - 2; r++) begin
            for (int c = 1; c <= N - 2; c++) begin
`ifdef BG_SKIP_EN
                if (mem[r*N + c] == 8'd0) begin
                    cost_sum += 3;
                    continue;
                end
                cost_sum += 39;
`else
                cost_sum += 37;
`endif
                for (int t = 0; t < 9; t++) begin
                    wr_t w;
                    w.id  = (r - 1) * (N - 2) + (c - 1);
                    w.tap = t;
                    w.val = int'(mem[(r - 1 + t / 3) * N + (c - 1 + t % 3)]);
                    exp_q.push_back(w);
                end
            end
        end
        t_exp = cost_sum + 1;
    endtask

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (chk_en) begin
            chk("busy", int'(busy), int'((pc >= 1 && pc <= t_exp) || (hold_mode && pc == t_exp + 2)));
            chk("done", int'(done), int'(pc == t_exp));
            if (kr_we) begin
                if (run == 0) begin
                    wr_t a;
                    a.id = int'(kr_identifier); a.tap = int'(kr_addr); a.val = int'(kr_data);
                    log_q.push_back(a);
                end
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    chk("kr_identifier", int'(kr_identifier), exp_q[0].id);
                    chk("kr_addr", int'(kr_addr), exp_q[0].tap);
                    chk("kr_data", int'(kr_data), exp_q[0].val);
                end
                run++;
            end else if (run != 0) begin
                chk("we_length", run, 2);
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                run = 0;
            end
            if (pc == t_exp + 1) chk("writes_left", exp_q.size(), 0);
            if (pc == t_exp + 2) begin
                chk_en = 1'b0;
                pass_fin = 1'b1;
            end
            pc++;
        end
    end

    task automatic run_pass(input bit hold);
        int d0;
        build_model();
        log_q.delete();
        run = 0;
        pass_fin = 1'b0;
        hold_mode = hold;
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1;
        pc = 0;
        chk_en = 1'b1;
        if (!hold) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        for (int i = 0; i < 4000 && !pass_fin; i++) @(negedge clk);
        if (!pass_fin) begin
            chk("pass_timeout", 0, 1);
            chk_en = 1'b0;
        end
        start = 1'b0;
        if (hold) begin
            @(posedge clk); #1 reset = 1'b1;
            @(posedge clk); #1 reset = 1'b0;
        end
        chk("done_pulses", done_cnt - d0, 1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_kr_we"}, int'(kr_we), 0);
        chk({tag, "_img_addr"}, int'(img_addr), 0);
        chk({tag, "_kr_addr"}, int'(kr_addr), 0);
        chk({tag, "_kr_data"}, int'(kr_data), 0);
        chk({tag, "_kr_id"}, int'(kr_identifier), 0);
    endtask

    initial begin
        int first_taps[9];
        int last_taps[9];
        int d0;
        first_taps = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
        last_taps  = '{45, 46, 47, 53, 54, 55, 61, 62, 63};
        for (int i = 0; i < N * N; i++) mem[i] = 8'(i);

        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        reset = 1'b0;

        // Pass 1: pixel = address; pin the model with literal taps and timing.
        run_pass(1'b0);
`ifdef BG_SKIP_EN
        chk("model_done_cycle", t_exp, 1405);
`else
        chk("model_done_cycle", t_exp, 1333);
`endif
        chk("write_count", log_q.size(), 324);
        if (log_q.size() == 324) begin
            for (int t = 0; t < 9; t++) begin
                chk("k0_tap", log_q[t].val, first_taps[t]);
                chk("k0_addr", log_q[t].tap, t);
                chk("k0_id", log_q[t].id, 0);
                chk("k35_tap", log_q[315 + t].val, last_taps[t]);
                chk("k35_id", log_q[315 + t].id, 35);
            end
        end
        @(negedge clk);
        chk("busy_after", int'(busy), 0);

        // Abort mid-pass with reset at cycle 500.
        d0 = done_cnt;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (499) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk_outputs_zero("abort");
        reset = 1'b0;
        chk("abort_no_done", done_cnt - d0, 0);
        run_pass(1'b0);

        // Random frame with start held high across DONE.
        for (int i = 0; i < N * N; i++) begin
`ifdef BG_SKIP_EN
            mem[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
`else
            mem[i] = 8'($urandom_range(0, 255));
`endif
        end
        run_pass(1'b1);

`ifdef BG_SKIP_EN
        for (int i = 0; i < N * N; i++) mem[i] = 8'd0;
        mem[9] = 8'd1;
        run_pass(1'b0);
        chk("bg_model_cycles", t_exp, 145);
        chk("bg_writes", log_q.size(), 9);
        for (int t = 0; t < log_q.size(); t++) chk("bg_id", log_q[t].id, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
